// File: rtl/mux2_arb_pkg.sv
// rtl/mux2_arb_pkg.sv - shared state encoding and requester indices for mux2_arbiter
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mux2_arb_hold_cnt.sv
// rtl/mux2_arb_hold_cnt.sv - saturating grant-hold counter with clear/enable, flags MAX_HOLD-1
module mux2_arb_hold_cnt #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt;

    // Clear wins over enable so a back-to-back owner switch restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/mux2_arbiter.sv
// rtl/mux2_arbiter.sv - two-requester round-robin arbiter driving a 2:1 mux select; MUX2_ARB_PREEMPT_EN enables hold-limit preemption
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic sel,
    output logic busy,
    output logic preempt
);

    arb_state_t state;
    arb_state_t nxt;
    logic       last;
    logic       at_limit;
    logic       force_sw;
    logic       entry;

    always_comb begin
        nxt      = state;
        force_sw = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    nxt = (last == REQ1) ? ST_OWN0 : ST_OWN1;
                end else if (req0) begin
                    nxt = ST_OWN0;
                end else if (req1) begin
                    nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!req0) begin
                    nxt = req1 ? ST_OWN1 : ST_IDLE;
                end else if (at_limit && req1) begin
                    nxt      = ST_OWN1;
                    force_sw = 1'b1;
                end
            end
            ST_OWN1: begin
                if (!req1) begin
                    nxt = req0 ? ST_OWN0 : ST_IDLE;
                end else if (at_limit && req0) begin
                    nxt      = ST_OWN0;
                    force_sw = 1'b1;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    assign entry = (nxt != state) && (nxt != ST_IDLE);

`ifdef MUX2_ARB_PREEMPT_EN
    mux2_arb_hold_cnt #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (entry),
        .en       (state != ST_IDLE),
        .at_limit (at_limit)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{MAX_HOLD, CNT_W};
    assign at_limit   = 1'b0;
`endif

    // Outputs are registered from the next state so they line up with the state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            sel     <= REQ0;
            busy    <= 1'b0;
            preempt <= 1'b0;
            last    <= REQ1;
        end else begin
            state   <= nxt;
            gnt0    <= (nxt == ST_OWN0);
            gnt1    <= (nxt == ST_OWN1);
            busy    <= (nxt != ST_IDLE);
            preempt <= force_sw;
            if (entry) begin
                last <= (nxt == ST_OWN1) ? REQ1 : REQ0;
                sel  <= (nxt == ST_OWN1) ? REQ1 : REQ0;
            end
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb/tb_mux2_arbiter.sv - directed and random checks of mux2_arbiter against an owner/last reference model
module tb_mux2_arbiter;

    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0 = 1'b0;
    logic req1 = 1'b0;
    logic gnt0, gnt1, sel, busy, preempt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: owner index (-1 = none), last owner, cycles the owner has held the grant.
    int own = -1;
    bit last = 1'b1;
    bit exp_sel = 1'b0;
    bit exp_pre = 1'b0;
    int held = 0;

    mux2_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .sel     (sel),
        .busy    (busy),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".gnt0"}, gnt0, own == 0);
        chk({ph, ".gnt1"}, gnt1, own == 1);
        chk({ph, ".busy"}, busy, own >= 0);
        chk({ph, ".sel"}, sel, exp_sel);
        chk({ph, ".preempt"}, preempt, exp_pre);
        chk({ph, ".excl"}, gnt0 & gnt1, 1'b0);
    endtask

    task automatic model_reset();
        own = -1;
        last = 1'b1;
        exp_sel = 1'b0;
        exp_pre = 1'b0;
        held = 0;
    endtask

    task automatic take(input int who);
        own = who;
        last = who[0];
        exp_sel = who[0];
        held = 1;
    endtask

    task automatic model_edge(input bit r0, input bit r1);
        int o;
        bit mine, other;
        exp_pre = 1'b0;
        if (own < 0) begin
            if (r0 && r1) take(last ? 0 : 1);
            else if (r0) take(0);
            else if (r1) take(1);
        end else begin
            o = own;
            mine = (o == 1) ? r1 : r0;
            other = (o == 1) ? r0 : r1;
            if (!mine) begin
                if (other) take(1 - o);
                else own = -1;
            end
`ifdef MUX2_ARB_PREEMPT_EN
            else if (other && held >= MAX_HOLD) begin
                take(1 - o);
                exp_pre = 1'b1;
            end
`endif
            else held++;
        end
    endtask

    task automatic step(input bit r0, input bit r1, input string ph);
        req0 = r0;
        req1 = r1;
        @(posedge clk);
        #1;
        model_edge(r0, r1);
        check_all(ph);
    endtask

    initial begin
        // Reset held with both requesters active.
        rst_n = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_all("rst");
        rst_n = 1'b1;
        step(1, 1, "rst_rel");
        chk("rst_rel.first_gnt0", gnt0, 1'b1);
        step(0, 0, "drain");
        step(0, 0, "drain");

        // Single requester 1 for five cycles.
        repeat (5) step(0, 1, "single");
        step(0, 0, "single_rel");
        chk("single_rel.sel_kept", sel, 1'b1);

        // Round-robin tie: owner drops for one cycle after three cycles of ownership.
        for (int i = 0; i < 16; i++) begin
            step(!(own == 0 && held == 3), !(own == 1 && held == 3), "rr");
        end
        step(0, 0, "drain");
        step(0, 0, "drain");

        // Direct handover 0 -> 1.
        step(1, 0, "ho");
        step(1, 1, "ho");
        step(0, 1, "ho_sw");
        chk("ho_sw.gnt1", gnt1, 1'b1);
        chk("ho_sw.sel", sel, 1'b1);

        // Asynchronous reset in the middle of an OWN1 cycle.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Hold-limit behaviour: both asserted, then requester 0 alone.
        repeat (10) step(1, 1, "hold_both");
        step(0, 0, "drain");
        step(0, 0, "drain");
        repeat (25) step(1, 0, "hold_solo");
        step(0, 0, "drain");

        // Random request patterns.
        repeat (400) step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
